// File: rtl/core_mem_np_if.sv
// KA10 memory bus bundle for NPORTS processor ports, all fields packed per port.
interface core_mem_np_if #(
    parameter int NPORTS = 4
);
    logic [NPORTS-1:0]    membus_rq_cyc;
    logic [NPORTS-1:0]    membus_rd_rq;
    logic [NPORTS-1:0]    membus_wr_rq;
    logic [NPORTS-1:0]    membus_wr_rs;
    logic [4*NPORTS-1:0]  membus_sel;
    logic [NPORTS-1:0]    membus_fmc_select;
    logic [15*NPORTS-1:0] membus_ma;
    logic [36*NPORTS-1:0] membus_mb_in;
    logic [36*NPORTS-1:0] membus_mb_out;
    logic [NPORTS-1:0]    membus_addr_ack;
    logic [NPORTS-1:0]    membus_rd_rs;

    modport master (
        output membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_wr_rs,
               membus_sel, membus_fmc_select, membus_ma, membus_mb_in,
        input  membus_mb_out, membus_addr_ack, membus_rd_rs
    );

    modport slave (
        input  membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_wr_rs,
               membus_sel, membus_fmc_select, membus_ma, membus_mb_in,
        output membus_mb_out, membus_addr_ack, membus_rd_rs
    );
endinterface

// File: rtl/core_mem_np.sv
// Multi-port KA10 core memory: arbitrated rd_rq/wr_rq/addr_ack/rd_rs/wr_rs cycles with
// read-modify-write, restore timing, per-port select codes and nonexistent-address qualification.
module core_mem_np #(
    parameter int          NPORTS    = 4,
    parameter int          ADDR_BITS = 14,
    parameter logic [15:0] MEMSEL    = 16'h0000,
    parameter int          PRIO_MODE = 0,
    parameter int          ACK_DLY   = 2,
    parameter int          RD_DLY    = 3,
    parameter int          WR_DLY    = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         power,
    core_mem_np_if.slave membus
);
    localparam int PW    = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int CW    = 8;
    localparam int WORDS = 1 << ADDR_BITS;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ACK     = 3'd1;
    localparam logic [2:0] S_RD      = 3'd2;
    localparam logic [2:0] S_WAIT_WR = 3'd3;
    localparam logic [2:0] S_RESTORE = 3'd4;

    logic                 rst_i;
    logic [2:0]           state_q;
    logic [CW-1:0]        cnt_q;
    logic [PW-1:0]        port_q;
    logic [PW-1:0]        last_q;
    logic [PW-1:0]        pick;
    logic                 found;
    logic                 rd_q;
    logic                 wr_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [NPORTS-1:0]    done_q;
    logic [NPORTS-1:0]    elig;
    logic [NPORTS-1:0]    ack_q;
    logic [NPORTS-1:0]    rd_rs_q;
    logic [36*NPORTS-1:0] mb_out_q;
    logic [35:0]          core_q [WORDS];
    logic [14:0]          ma_i;
    int                   arb_start;
    int                   arb_idx;
    logic                 p_rq_cyc;
    logic                 p_wr_rs;
    logic [35:0]          p_mb_in;

    assign rst_i    = reset | ~power;
    assign p_rq_cyc = membus.membus_rq_cyc[port_q];
    assign p_wr_rs  = membus.membus_wr_rs[port_q];
    assign p_mb_in  = membus.membus_mb_in[36*int'(port_q) +: 36];

    // Address bits above ADDR_BITS mark a nonexistent word; fast-memory addresses belong to the requester.
    always_comb begin
        elig = '0;
        ma_i = '0;
        for (int i = 0; i < NPORTS; i++) begin
            ma_i    = membus.membus_ma[15*i +: 15];
            elig[i] = membus.membus_rq_cyc[i]
                   && (membus.membus_rd_rq[i] || membus.membus_wr_rq[i])
                   && (membus.membus_sel[4*i +: 4] == MEMSEL[4*i +: 4])
                   && ((ma_i >> ADDR_BITS) == 15'd0)
                   && !(membus.membus_fmc_select[i] && (ma_i < 15'd16))
                   && !done_q[i];
        end
    end

    // Rotating mode starts the search just past the last granted port.
    always_comb begin
        found     = 1'b0;
        pick      = '0;
        arb_idx   = 0;
        arb_start = (PRIO_MODE == 1) ? (int'(last_q) + 1) % NPORTS : 0;
        for (int k = 0; k < NPORTS; k++) begin
            arb_idx = (arb_start + k) % NPORTS;
            if (!found && elig[PW'(arb_idx)]) begin
                found = 1'b1;
                pick  = PW'(arb_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            port_q   <= '0;
            last_q   <= PW'(NPORTS - 1);
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            done_q   <= '0;
            ack_q    <= '0;
            rd_rs_q  <= '0;
            mb_out_q <= '0;
        end else begin
            ack_q   <= '0;
            rd_rs_q <= '0;
            for (int i = 0; i < NPORTS; i++) begin
                if (!membus.membus_rq_cyc[i]) begin
                    done_q[i]           <= 1'b0;
                    mb_out_q[36*i +: 36] <= '0;
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        port_q  <= pick;
                        last_q  <= pick;
                        rd_q    <= membus.membus_rd_rq[pick];
                        wr_q    <= membus.membus_wr_rq[pick];
                        cnt_q   <= CW'(ACK_DLY);
                        state_q <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!p_rq_cyc) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        ack_q[port_q]  <= 1'b1;
                        done_q[port_q] <= 1'b1;
                        cnt_q          <= CW'(RD_DLY);
                        state_q        <= rd_q ? S_RD : S_WAIT_WR;
                    end
                end
                S_RD: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        rd_rs_q[port_q]                  <= 1'b1;
                        mb_out_q[36*int'(port_q) +: 36] <= core_q[addr_q];
                        cnt_q                            <= CW'(WR_DLY);
                        state_q                          <= wr_q ? S_WAIT_WR : S_RESTORE;
                    end
                end
                S_WAIT_WR: begin
                    if (!p_rq_cyc) begin
                        state_q <= S_IDLE;
                    end else if (p_wr_rs) begin
                        cnt_q   <= CW'(WR_DLY);
                        state_q <= S_RESTORE;
                    end
                end
                S_RESTORE: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                    else             state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The array reads non-destructively, so the restore phase is timing only; real writes happen on wr_rs.
    always_ff @(posedge clk) begin
        if (!rst_i && (state_q == S_WAIT_WR) && p_rq_cyc && p_wr_rs)
            core_q[addr_q] <= p_mb_in;
    end

    always_ff @(posedge clk) begin
        if ((state_q == S_IDLE) && found)
            addr_q <= ADDR_BITS'(membus.membus_ma >> (15 * int'(pick)));
    end

    assign membus.membus_addr_ack = ack_q;
    assign membus.membus_rd_rs    = rd_rs_q;
    assign membus.membus_mb_out   = mb_out_q;
endmodule

// File: tb/tb_core_mem_np.sv
// Bench for core_mem_np: directed bus cycles plus a randomized mix against an associative-array memory model.
module tb_core_mem_np;
    localparam int NP      = 4;
    localparam int AB      = 14;
    localparam int ACK_DLY = 2;
    localparam int RD_DLY  = 3;
    localparam int WR_DLY  = 4;
    // Negedges from driving a request to seeing ack: one grant edge, then ACK_DLY+1 edges.
    localparam int ACK_LAT = ACK_DLY + 2;
    localparam int RD_LAT  = RD_DLY + 1;
    localparam int BUDGET  = 40;

    logic clk = 1'b0;
    logic reset;
    logic power;
    always #5 clk = ~clk;

    logic [NP-1:0]    rq_cyc [2];
    logic [NP-1:0]    rd_rq  [2];
    logic [NP-1:0]    wr_rq  [2];
    logic [NP-1:0]    wr_rs  [2];
    logic [NP-1:0]    fmc    [2];
    logic [4*NP-1:0]  sel    [2];
    logic [15*NP-1:0] ma     [2];
    logic [36*NP-1:0] mb_in  [2];
    logic [NP-1:0]    ack    [2];
    logic [NP-1:0]    rd_rs  [2];
    logic [36*NP-1:0] mb_out [2];

    core_mem_np_if #(.NPORTS(NP)) bus_f ();
    core_mem_np_if #(.NPORTS(NP)) bus_r ();

    assign bus_f.membus_rq_cyc     = rq_cyc[0];
    assign bus_f.membus_rd_rq      = rd_rq[0];
    assign bus_f.membus_wr_rq      = wr_rq[0];
    assign bus_f.membus_wr_rs      = wr_rs[0];
    assign bus_f.membus_fmc_select = fmc[0];
    assign bus_f.membus_sel        = sel[0];
    assign bus_f.membus_ma         = ma[0];
    assign bus_f.membus_mb_in      = mb_in[0];
    assign ack[0]                  = bus_f.membus_addr_ack;
    assign rd_rs[0]                = bus_f.membus_rd_rs;
    assign mb_out[0]               = bus_f.membus_mb_out;

    assign bus_r.membus_rq_cyc     = rq_cyc[1];
    assign bus_r.membus_rd_rq      = rd_rq[1];
    assign bus_r.membus_wr_rq      = wr_rq[1];
    assign bus_r.membus_wr_rs      = wr_rs[1];
    assign bus_r.membus_fmc_select = fmc[1];
    assign bus_r.membus_sel        = sel[1];
    assign bus_r.membus_ma         = ma[1];
    assign bus_r.membus_mb_in      = mb_in[1];
    assign ack[1]                  = bus_r.membus_addr_ack;
    assign rd_rs[1]                = bus_r.membus_rd_rs;
    assign mb_out[1]               = bus_r.membus_mb_out;

    core_mem_np #(.NPORTS(NP), .ADDR_BITS(AB), .MEMSEL(16'h0000), .PRIO_MODE(0),
                  .ACK_DLY(ACK_DLY), .RD_DLY(RD_DLY), .WR_DLY(WR_DLY))
        dut_f (.clk(clk), .reset(reset), .power(power), .membus(bus_f));

    core_mem_np #(.NPORTS(NP), .ADDR_BITS(AB), .MEMSEL(16'h0000), .PRIO_MODE(1),
                  .ACK_DLY(ACK_DLY), .RD_DLY(RD_DLY), .WR_DLY(WR_DLY))
        dut_r (.clk(clk), .reset(reset), .power(power), .membus(bus_r));

    int errors = 0;
    int checks = 0;
    logic [35:0] model [logic [14:0]];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_all();
        for (int d = 0; d < 2; d++) begin
            rq_cyc[d] = '0; rd_rq[d] = '0; wr_rq[d] = '0; wr_rs[d] = '0;
            fmc[d] = '0; sel[d] = '0; ma[d] = '0; mb_in[d] = '0;
        end
    endtask

    task automatic raise(input int d, input int p, input bit rd, input bit wr,
                         input logic [14:0] a, input bit f, input logic [3:0] s);
        rq_cyc[d][p] = 1'b1;
        rd_rq[d][p]  = rd;
        wr_rq[d][p]  = wr;
        fmc[d][p]    = f;
        ma[d][15*p +: 15] = a;
        sel[d][4*p +: 4]  = s;
    endtask

    task automatic drop(input int d, input int p);
        rq_cyc[d][p] = 1'b0;
        rd_rq[d][p]  = 1'b0;
        wr_rq[d][p]  = 1'b0;
    endtask

    task automatic wait_ack(input int d, input int p, output int n);
        n = -1;
        for (int i = 1; i <= BUDGET && n < 0; i++) begin
            @(negedge clk);
            if (ack[d][p]) n = i;
        end
    endtask

    task automatic wait_rd_rs(input int d, input int p, output int n);
        n = -1;
        for (int i = 1; i <= BUDGET && n < 0; i++) begin
            @(negedge clk);
            if (rd_rs[d][p]) n = i;
        end
    endtask

    task automatic wait_any_ack(input int d, output int g);
        g = -1;
        for (int i = 1; i <= BUDGET && g < 0; i++) begin
            @(negedge clk);
            for (int q = NP - 1; q >= 0; q--)
                if (ack[d][q]) g = q;
        end
    endtask

    task automatic count_acks(input int d, input int p, input int cycles, output int seen);
        seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (ack[d][p]) seen++;
        end
    endtask

    task automatic do_write(input int p, input logic [14:0] a, input logic [35:0] data, input int dly);
        int n;
        raise(0, p, 1'b0, 1'b1, a, 1'b0, 4'h0);
        wait_ack(0, p, n);
        check("wr_ack_lat", n, ACK_LAT);
        @(negedge clk);
        check("ack_pulse", ack[0][p], 1'b0);
        repeat (dly - 1) @(negedge clk);
        wr_rs[0][p] = 1'b1;
        mb_in[0][36*p +: 36] = data;
        @(negedge clk);
        wr_rs[0][p] = 1'b0;
        drop(0, p);
        model[a] = data;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_read(input int p, input logic [14:0] a, input bit f, input bit rmw,
                           input logic [35:0] wdata, input int dly, input bit hold);
        int n;
        int seen;
        logic [35:0] exp;
        exp = model[a];
        raise(0, p, 1'b1, rmw, a, f, 4'h0);
        wait_ack(0, p, n);
        check("rd_ack_lat", n, ACK_LAT);
        wait_rd_rs(0, p, n);
        check("rd_rs_lat", n, RD_LAT);
        check("rd_data", mb_out[0][36*p +: 36], exp);
        if (rmw) begin
            repeat (dly) @(negedge clk);
            wr_rs[0][p] = 1'b1;
            mb_in[0][36*p +: 36] = wdata;
            @(negedge clk);
            wr_rs[0][p] = 1'b0;
            model[a] = wdata;
        end
        if (hold) begin
            count_acks(0, p, 15, seen);
            check("held_no_ack", seen, 0);
            check("mbout_held", mb_out[0][36*p +: 36], exp);
        end
        drop(0, p);
        @(negedge clk);
        check("mbout_clr", mb_out[0][36*p +: 36], 36'd0);
        repeat (8) @(negedge clk);
    endtask

    task automatic arb_scenario(input int d, input string tag, input bit rerq, input int ng,
                                input int e0, input int e1, input int e2, input int e3);
        int exp_g [4];
        int g;
        int n;
        exp_g = '{e0, e1, e2, e3};
        raise(d, 0, 1'b1, 1'b0, 15'o20, 1'b0, 4'h0);
        raise(d, 3, 1'b1, 1'b0, 15'o100, 1'b0, 4'h0);
        for (int k = 0; k < ng; k++) begin
            wait_any_ack(d, g);
            check(tag, g, exp_g[k]);
            if (g >= 0) begin
                wait_rd_rs(d, g, n);
                drop(d, g);
                @(negedge clk);
                if (rerq) raise(d, g, 1'b1, 1'b0, (g == 0) ? 15'o20 : 15'o100, 1'b0, 4'h0);
            end
        end
        drop(d, 0);
        drop(d, 3);
        repeat (12) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        int g;
        logic [63:0] r;
        logic [14:0] addrs [6];

        clear_all();
        reset = 1'b1;
        power = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_ack", ack[d], '0);
            check("reset_rd_rs", rd_rs[d], '0);
            check("reset_mbout", |mb_out[d], 1'b0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Read of 'o20 with fmc_select set: 16 is the first address outside fast memory.
        do_write(0, 15'o20, 36'o200100_000001, 2);
        do_read(0, 15'o20, 1'b1, 1'b0, '0, 0, 1'b1);

        do_write(1, 15'o100, 36'o777777_000000, 5);
        do_read(1, 15'o100, 1'b0, 1'b0, '0, 0, 1'b0);

        do_write(2, 15'd5, 36'd1, 1);
        do_read(2, 15'd5, 1'b0, 1'b1, 36'd2, 2, 1'b0);
        do_read(2, 15'd5, 1'b0, 1'b0, '0, 0, 1'b0);

        do_write(3, 15'o37777, 36'o525252_525252, 3);
        do_read(3, 15'o37777, 1'b0, 1'b0, '0, 0, 1'b0);

        raise(0, 0, 1'b1, 1'b0, 15'o7, 1'b1, 4'h0);
        count_acks(0, 0, 12, seen);
        check("fmc_no_ack", seen, 0);
        drop(0, 0);
        raise(0, 1, 1'b1, 1'b0, 15'o40000, 1'b0, 4'h0);
        count_acks(0, 1, 12, seen);
        check("nxm_no_ack", seen, 0);
        drop(0, 1);
        raise(0, 2, 1'b1, 1'b0, 15'o20, 1'b0, 4'h1);
        count_acks(0, 2, 12, seen);
        check("sel_no_ack", seen, 0);
        drop(0, 2);
        repeat (4) @(negedge clk);

        raise(0, 3, 1'b1, 1'b0, 15'o20, 1'b0, 4'h0);
        @(negedge clk);
        drop(0, 3);
        count_acks(0, 3, 10, seen);
        check("withdraw_ack_no_ack", seen, 0);
        do_read(3, 15'o20, 1'b0, 1'b0, '0, 0, 1'b0);

        raise(0, 1, 1'b0, 1'b1, 15'o100, 1'b0, 4'h0);
        mb_in[0][36*1 +: 36] = 36'o111111_111111;
        wait_ack(0, 1, n);
        check("ww_ack_lat", n, ACK_LAT);
        repeat (3) @(negedge clk);
        drop(0, 1);
        repeat (8) @(negedge clk);
        do_read(1, 15'o100, 1'b0, 1'b0, '0, 0, 1'b0);

        // Port 2 keeps a read word on its bus while port 0 sits in WAIT_WR when reset hits.
        raise(0, 2, 1'b1, 1'b0, 15'o100, 1'b0, 4'h0);
        wait_ack(0, 2, n);
        wait_rd_rs(0, 2, n);
        check("pre_rst_mbout", mb_out[0][36*2 +: 36], model[15'o100]);
        repeat (6) @(negedge clk);
        raise(0, 0, 1'b0, 1'b1, 15'o20, 1'b0, 4'h0);
        mb_in[0][0 +: 36] = 36'o123456_654321;
        wait_ack(0, 0, n);
        check("rst_wr_ack_lat", n, ACK_LAT);
        @(negedge clk);
        reset = 1'b1;
        drop(0, 0);
        @(negedge clk);
        check("rst_mid_ack", ack[0], '0);
        check("rst_mid_rd_rs", rd_rs[0], '0);
        check("rst_mid_mbout", |mb_out[0], 1'b0);
        reset = 1'b0;
        drop(0, 2);
        repeat (4) @(negedge clk);
        do_read(0, 15'o20, 1'b0, 1'b0, '0, 0, 1'b0);

        raise(0, 3, 1'b1, 1'b0, 15'o20, 1'b0, 4'h0);
        wait_ack(0, 3, n);
        wait_rd_rs(0, 3, n);
        check("pre_pwr_mbout", mb_out[0][36*3 +: 36], model[15'o20]);
        power = 1'b0;
        @(negedge clk);
        check("pwr_mbout", mb_out[0][36*3 +: 36], 36'd0);
        power = 1'b1;
        drop(0, 3);
        repeat (8) @(negedge clk);

        arb_scenario(0, "arb_fixed", 1'b0, 2, 0, 3, 0, 0);
        arb_scenario(0, "arb_fixed_rerq", 1'b1, 3, 0, 0, 0, 0);
        arb_scenario(1, "arb_rotating", 1'b1, 4, 0, 3, 0, 3);

        addrs = '{15'o200, 15'o201, 15'o1234, 15'o7777, 15'o37777, 15'o0};
        for (int i = 0; i < 6; i++) begin
            r = {$urandom, $urandom};
            do_write(i % NP, addrs[i], r[35:0], 1);
        end
        for (int i = 0; i < 24; i++) begin
            int op;
            int p;
            logic [14:0] a;
            op = int'($urandom_range(0, 2));
            p  = int'($urandom_range(0, NP - 1));
            a  = addrs[$urandom_range(0, 5)];
            r  = {$urandom, $urandom};
            case (op)
                0:       do_write(p, a, r[35:0], int'($urandom_range(1, 6)));
                1:       do_read(p, a, 1'b0, 1'b0, '0, 0, 1'b0);
                default: do_read(p, a, 1'b0, 1'b1, r[35:0], int'($urandom_range(0, 5)), 1'b0);
            endcase
        end
        for (int i = 0; i < 6; i++)
            do_read(i % NP, addrs[i], 1'b0, 1'b0, '0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/core_mem_np.md
Name: core_mem_np

Overview:
- Parametrised multi-port core memory model for the KA10 memory bus.
- Successor to the single-port memory instance wired to the processor. Adds a configurable port count, a per-port memory-select code, selectable arbitration, configurable depth and a cycle-timing model.
- Implements the rd_rq / wr_rq / addr_ack / rd_rs / wr_rs handshake, including read-modify-write and destructive-read restore.
- Sits beside other memories; each port's mb_out is wired-OR'd onto its processor's data bus.

Parameters:
- NPORTS, 4: number of bus ports, 1..4.
- ADDR_BITS, 14: words = 2^ADDR_BITS, max 15 (default is 'o40000 words).
- MEMSEL, 16'h0000: packed 4-bit select code per port; port i uses bits [4i+3:4i].
- PRIO_MODE, 0: 0 = fixed priority, port 0 highest; 1 = rotating priority, the last-granted port becomes lowest.
- ACK_DLY, 2: cycles from grant to addr_ack.
- RD_DLY, 3: cycles from addr_ack to rd_rs.
- WR_DLY, 4: cycles for a write or restore before idle.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- power  in  1  low forces the reset state.
- membus_rq_cyc  in  NPORTS  cycle request, per port.
- membus_rd_rq  in  NPORTS  read request.
- membus_wr_rq  in  NPORTS  write request.
- membus_wr_rs  in  NPORTS  write restart (data valid), pulse.
- membus_sel  in  4*NPORTS  memory select code.
- membus_fmc_select  in  NPORTS  fast memory enabled in the requester.
- membus_ma  in  15*NPORTS  word address.
- membus_mb_in  in  36*NPORTS  write data.
- membus_mb_out  out  36*NPORTS  read data, zero when not driving.
- membus_addr_ack  out  NPORTS  address acknowledge, 1-cycle pulse.
- membus_rd_rs  out  NPORTS  read restart (data valid), 1-cycle pulse.

Behaviour:
- Clock and reset: one clock clk. reset is synchronous, active-high; `power` low has the same effect.
- Reset state:
  - All outputs 0.
  - FSM in IDLE.
  - Per-port done bits cleared.
  - Core array contents untouched.
- Port i is eligible when all of the following hold:
  - rq_cyc[i] and (rd_rq[i] or wr_rq[i]);
  - sel[i] == MEMSEL[i];
  - ma[i] bits above ADDR_BITS are all 0; otherwise the address is nonexistent, there is never an ack, and the requester times out;
  - not (fmc_select[i] and ma[i] < 16);
  - done[i] == 0.
- done[i] is set on addr_ack[i] and cleared in any cycle where rq_cyc[i] == 0. This prevents a held request being served twice.
- IDLE:
  - Pick one eligible port per PRIO_MODE.
  - Latch port, address, rd and wr flags.
  - Load counter = ACK_DLY and go to ACK.
  - Nothing eligible: stay in IDLE.
- ACK:
  - When the counter reaches 0, pulse addr_ack[p] for 1 cycle.
  - If rd: go to RD with counter = RD_DLY.
  - Otherwise: go to WAIT_WR.
  - Latency from grant to ack is ACK_DLY+1 cycles.
- RD:
  - At count 0, load mb_out[p] = core[addr] and pulse rd_rs[p] for 1 cycle.
  - rd and wr both set (read-modify-write): go to WAIT_WR.
  - Read only: go to RESTORE with counter = WR_DLY; the restore writes the same data back.
- WAIT_WR:
  - Wait for wr_rs[p]; this may take unbounded time.
  - On wr_rs[p], latch mb_in[p], write core[addr], load counter = WR_DLY and go to RESTORE.
- RESTORE: count to 0, then go to IDLE. Arbitration resumes the next cycle.
- mb_out[p]: held from the rd_rs cycle until rq_cyc[p] is seen low, then cleared to 0. mb_out of non-granted ports is always 0.
- Simultaneous eligible requests:
  - Fixed mode: lowest index wins.
  - Rotating mode: search starts at last-granted+1, modulo NPORTS.
- Request withdrawn (rq_cyc drops) before ack:
  - In ACK state: cycle is abandoned, no ack, return to IDLE.
  - In WAIT_WR: cycle is abandoned with no write; core contents are unchanged.
- Reset mid-cycle: any pending write is discarded; outputs are zeroed immediately in the next cycle.
- Addresses use the low ADDR_BITS of ma; no wrap-around is possible because high bits are qualified.

Test Plan:
- Core['o20] = 36'o200100_000001, port0 read with sel=0 and ma='o20:
  - addr_ack at grant+3;
  - rd_rs 4 cycles later with mb_out0 = 36'o200100_000001;
  - mb_out0 returns to 0 after rq_cyc drops.
- Port1 write ma='o100, mb_in = 36'o777777_000000, wr_rs 5 cycles after ack: core['o100] updated after wr_rs; a subsequent port1 read returns the value.
- Read-modify-write on port2, ma=5, core=1, write 2: rd_rs carries 1; core=2 only after wr_rs.
- Ports 0 and 3 request on the same cycle, PRIO_MODE=0: port0 served, port3 served next. With PRIO_MODE=1 and repeated requests, grants alternate 0,3,0,3.
- No ack for: ma=7 with fmc_select=1; ma='o40000 with ADDR_BITS=14; sel mismatch. A held rq_cyc after ack gets no second ack until it drops.
- Reset asserted during WAIT_WR: no write occurs; all outputs 0 next cycle; next request is served normally.
